fetch_unit: RTL and testbench

//  Instruction fetch stage for the 8-bit core; produces the instruction stream the decode stage consumes.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 8-bit core.
// Owns the PC and reads a synchronous instruction memory with one cycle of
// read latency. Returned words go into a 2-entry FIFO whose head entry drives
// decode over a valid/ready handshake. A taken branch accepted by decode
// flushes the FIFO, drops the word currently returning from memory and
// reloads the PC.
module fetch_unit #(
    parameter int unsigned IW       = 8,
    parameter int unsigned IMW      = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req_o,
    output logic [IMW-1:0] imem_addr_o,
    input  logic [IW-1:0]  imem_rdata_i,
    output logic [IW-1:0]  instr_o,
    output logic [IMW-1:0] instr_pc_o,
    output logic           instr_valid_o,
    input  logic           instr_ready_i,
    input  logic           branch_taken_i,
    input  logic [IMW-1:0] branch_target_i,
    input  logic           halt_i
);

    localparam logic [IMW-1:0] RESET_PC_V = IMW'(RESET_PC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IMW-1:0] pc_q, pc_d;
    logic           inflight_q, inflight_d;
    logic [IMW-1:0] rd_pc_q, rd_pc_d;        // address of the word now in flight
    logic [1:0]     count_q, count_d;
    logic [IW-1:0]  head_instr_q, head_instr_d;
    logic [IMW-1:0] head_pc_q, head_pc_d;
    logic [IW-1:0]  tail_instr_q, tail_instr_d;
    logic [IMW-1:0] tail_pc_q, tail_pc_d;

    logic           pop_s;
    logic           redirect_s;
    logic           push_s;
    logic           issue_s;
    logic [2:0]     occupancy_s;

    // Handshake decode and the issue decision. The occupancy term counts the
    // slots that will be busy at the end of this cycle, so a word returning
    // next cycle always finds room.
    always_comb begin
        pop_s       = (count_q != 2'd0) & instr_ready_i;
        redirect_s  = pop_s & branch_taken_i;
        push_s      = inflight_q & ~redirect_s;
        occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s     = (state_q == ST_RUN) & ~halt_i & ~redirect_s & (occupancy_s < 3'd2);
    end

    // Next-state logic of the run/halt controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (halt_i) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!halt_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // PC update and in-flight tracking; a redirect never coincides with an issue.
    always_comb begin
        pc_d       = pc_q;
        rd_pc_d    = rd_pc_q;
        inflight_d = issue_s;
        if (redirect_s) begin
            pc_d = branch_target_i;
        end else if (issue_s) begin
            pc_d    = pc_q + IMW'(1);
            rd_pc_d = pc_q;
        end else begin
            pc_d = pc_q;
        end
    end

    // Two-entry FIFO kept as head/tail registers so the head drives decode
    // directly; the head keeps its last value when the FIFO empties.
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (redirect_s) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_s) begin
                        head_instr_d = imem_rdata_i;
                        head_pc_d    = rd_pc_q;
                        count_d      = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                2'd1: begin
                    case ({push_s, pop_s})
                        2'b11: begin
                            head_instr_d = imem_rdata_i;
                            head_pc_d    = rd_pc_q;
                        end
                        2'b10: begin
                            tail_instr_d = imem_rdata_i;
                            tail_pc_d    = rd_pc_q;
                            count_d      = 2'd2;
                        end
                        2'b01:   count_d = 2'd0;
                        default: count_d = count_q;
                    endcase
                end
                2'd2: begin
                    case ({push_s, pop_s})
                        2'b11: begin
                            head_instr_d = tail_instr_q;
                            head_pc_d    = tail_pc_q;
                            tail_instr_d = imem_rdata_i;
                            tail_pc_d    = rd_pc_q;
                        end
                        2'b01: begin
                            head_instr_d = tail_instr_q;
                            head_pc_d    = tail_pc_q;
                            count_d      = 2'd1;
                        end
                        default: count_d = count_q;
                    endcase
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    // State registers; reset discards buffered and in-flight words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC_V;
            inflight_q   <= 1'b0;
            rd_pc_q      <= '0;
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            rd_pc_q      <= rd_pc_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign imem_req_o    = issue_s;
    assign imem_addr_o   = pc_q;
    assign instr_o       = head_instr_q;
    assign instr_pc_o    = head_pc_q;
    assign instr_valid_o = (count_q != 2'd0);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_fetch_unit;

    localparam int IW  = 8;
    localparam int IMW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           imem_req;
    logic [IMW-1:0] imem_addr;
    logic [IW-1:0]  imem_rdata = 8'h00;
    logic [IW-1:0]  instr;
    logic [IMW-1:0] instr_pc;
    logic           instr_valid;
    logic           instr_ready = 1'b0;
    logic           branch_taken = 1'b0;
    logic [IMW-1:0] branch_target = 4'd0;
    logic           halt = 1'b0;

    logic [IW-1:0]  mem [16];

    fetch_unit #(.IW(IW), .IMW(IMW), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_rdata_i   (imem_rdata),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .halt_i         (halt)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory, one cycle of read latency.
    always @(posedge clk) begin
        if (imem_req === 1'b1) imem_rdata <= mem[imem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          cyc;
    bit          prev_halt;
    logic [3:0]  m_pc;
    logic [11:0] mq[$];
    bit          m_infl;
    logic [3:0]  m_infl_pc;
    int          first_valid_cyc;
    int          acc_pc[$];
    int          acc_instr[$];
    int          acc_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int acc_at(input int i);
        if (i < 0 || i >= acc_pc.size()) return -1;
        return acc_pc[i];
    endfunction

    function automatic int acc_cyc_at(input int i);
        if (i < 0 || i >= acc_cyc.size()) return -1000;
        return acc_cyc[i];
    endfunction

    task automatic model_reset();
        cyc             = 0;
        prev_halt       = 1'b0;
        m_pc            = 4'd0;
        mq.delete();
        m_infl          = 1'b0;
        m_infl_pc       = 4'd0;
        first_valid_cyc = -1;
    endtask

    task automatic drive(input bit r, input bit bt, input logic [3:0] tgt, input bit h);
        instr_ready   = r;
        branch_taken  = bt;
        branch_target = tgt;
        halt          = h;
        #1;
    endtask

    // Compare DUT against the model for this cycle, then advance the model
    // to the next cycle and wait for the next falling edge.
    task automatic tick();
        bit          run;
        bit          pop;
        bit          redir;
        bit          req;
        int          occ;
        logic [11:0] item;
        logic [11:0] head;
        item  = 12'h000;
        head  = 12'h000;
        run   = (cyc == 1) || (cyc >= 2 && !prev_halt);
        pop   = (mq.size() > 0) && instr_ready;
        redir = pop && branch_taken;
        occ   = mq.size() + int'(m_infl) - int'(pop);
        req   = run && !halt && !redir && (occ < 2);
        chk("imem_req", imem_req, req);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            head = mq[0];
            chk("instr", instr, head[11:4]);
            chk("instr_pc", instr_pc, head[3:0]);
        end
        if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (instr_valid === 1'b1 && instr_ready) begin
            acc_pc.push_back(int'(instr_pc));
            acc_instr.push_back(int'(instr));
            acc_cyc.push_back(cyc);
        end
        if (m_infl) item = {mem[m_infl_pc], m_infl_pc};
        if (redir) begin
            mq.delete();
            m_pc = branch_target;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(item);
        end
        if (req) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 4'd1;
        end
        m_infl    = req;
        prev_halt = halt;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input bit r, input bit h);
        for (int k = 0; k < n; k++) begin
            drive(r, 1'b0, 4'd0, h);
            tick();
        end
    endtask

    // Assert reset (possibly mid-cycle), check outputs, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst imem_req", imem_req, 1'b0);
        chk("rst imem_addr", imem_addr, 4'd0);
        chk("rst instr_valid", instr_valid, 1'b0);
        chk("rst instr", instr, 8'h00);
        chk("rst instr_pc", instr_pc, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst held valid", instr_valid, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int mark;
        int reqs;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
        @(negedge clk);
        do_reset();

        // Cold start streaming, then a taken branch at pc 3 to target 9
        run_n(6, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 4'd9, 1'b0);
        chk("t4 branch head pc", instr_pc, 4'd3);
        tick();
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        chk("t4 N+1 addr", imem_addr, 4'd9);
        chk("t4 N+1 req", imem_req, 1'b1);
        tick();
        run_n(1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        chk("t4 N+3 valid", instr_valid, 1'b1);
        chk("t4 N+3 pc", instr_pc, 4'd9);
        tick();
        run_n(3, 1'b1, 1'b0);
        chk("t1 first valid cycle", first_valid_cyc, 3);
        chk("t1 acc0 pc", acc_at(0), 0);
        chk("t1 acc1 pc", acc_at(1), 1);
        chk("t1 acc3 pc", acc_at(3), 3);
        chk("t1 acc0 instr", acc_instr.size() > 0 ? acc_instr[0] : -1, 8'h10);
        chk("t1 acc3 instr", acc_instr.size() > 3 ? acc_instr[3] : -1, 8'h13);
        chk("t1 acc3 cycle", acc_cyc_at(3), 6);
        chk("t4 acc4 pc", acc_at(4), 9);
        chk("t4 acc4 cycle", acc_cyc_at(4), 9);
        chk("t4 acc5 pc", acc_at(5), 10);
        reqs = 0;
        foreach (acc_pc[i]) if (acc_pc[i] == 4 || acc_pc[i] == 5) reqs++;
        chk("t4 squashed pcs presented", reqs, 0);

        // Wrap-around streaming from pc 14
        drive(1'b1, 1'b1, 4'd14, 1'b0);
        tick();
        mark = acc_pc.size();
        run_n(8, 1'b1, 1'b0);
        chk("t2 pc 14", acc_at(mark), 14);
        chk("t2 pc 15", acc_at(mark + 1), 15);
        chk("t2 pc 0", acc_at(mark + 2), 0);
        chk("t2 pc 1", acc_at(mark + 3), 1);
        chk("t2 no gap", acc_cyc_at(mark + 3) - acc_cyc_at(mark), 3);

        // Backpressure right after a redirect to pc 2
        drive(1'b1, 1'b1, 4'd2, 1'b0);
        tick();
        reqs = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b0);
            reqs += int'(imem_req);
            tick();
        end
        chk("t3 reqs while stalled", reqs, 2);
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        chk("t3 head pc while stalled", instr_pc, 4'd2);
        mark = acc_pc.size();
        run_n(6, 1'b1, 1'b0);
        chk("t3 pc 2", acc_at(mark), 2);
        chk("t3 pc 3", acc_at(mark + 1), 3);
        chk("t3 pc 4", acc_at(mark + 2), 4);
        chk("t3 pc 5", acc_at(mark + 3), 5);
        chk("t3 no gap", acc_cyc_at(mark + 3) - acc_cyc_at(mark), 3);

        // Halt for 4 cycles while streaming
        mark = acc_pc.size();
        reqs = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 4'd0, 1'b1);
            reqs += int'(imem_req);
            tick();
        end
        chk("t5 reqs while halted", reqs, 0);
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        chk("t5 drained", instr_valid, 1'b0);
        chk("t5 no req leaving halt", imem_req, 1'b0);
        tick();
        run_n(6, 1'b1, 1'b0);
        for (int i = mark - 1; i < acc_pc.size() - 1; i++) begin
            chk("t5 sequential", acc_at(i + 1), (acc_at(i) + 1) % 16);
        end

        // Reset with the FIFO full, then cold start again
        drive(1'b1, 1'b1, 4'd7, 1'b0);
        tick();
        run_n(3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        chk("t6 pre-reset valid", instr_valid, 1'b1);
        do_reset();
        mark = acc_pc.size();
        run_n(6, 1'b1, 1'b0);
        chk("t6 first valid cycle", first_valid_cyc, 3);
        chk("t6 pc 0", acc_at(mark), 0);
        chk("t6 pc 1", acc_at(mark + 1), 1);
        chk("t6 instr", acc_instr.size() > mark ? acc_instr[mark] : -1, 8'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
